// File: rtl/td4_pkg.sv
// td4_pkg: shared types and constants for the TD4 program controller slice.
// State encoding, program-store geometry and instruction field positions.
package td4_pkg;

    localparam int unsigned TD4_ADDR_W  = 4;
    localparam int unsigned TD4_DATA_W  = 8;

    // Instruction fields: opcode in the high nibble, immediate in the low nibble.
    localparam int unsigned TD4_OP_MSB  = 7;
    localparam int unsigned TD4_OP_LSB  = 4;
    localparam int unsigned TD4_IMM_MSB = 3;
    localparam int unsigned TD4_IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } td4_state_e;

    function automatic logic [3:0] td4_opcode(input logic [TD4_DATA_W-1:0] instr);
        return instr[TD4_OP_MSB:TD4_OP_LSB];
    endfunction

endpackage

// File: rtl/td4_prog_ctrl_if.sv
// td4_prog_ctrl_if: program loader byte stream and load sequencing signals.
// The loader drives the master side; td4_prog_ctrl is the slave.
interface td4_prog_ctrl_if
    import td4_pkg::*;
#(
    parameter int unsigned DATA_W = TD4_DATA_W
);
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              load_done;

    modport master (
        output load_start, ld_valid, ld_data,
        input  ld_ready, load_done
    );

    modport slave (
        input  load_start, ld_valid, ld_data,
        output ld_ready, load_done
    );
endinterface

// File: rtl/td4_prog_mem.sv
// td4_prog_mem: depth x DATA_W program store in flops.
// Async clear, one synchronous write port, one zero-latency read port
// (a same-cycle write to the read address is seen only after the edge).
module td4_prog_mem #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: whole array cleared on reset, single-byte writes otherwise.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/td4_prog_ctrl.sv
// td4_prog_ctrl: TD4 program-memory owner and run controller.
// Sequences the core through HALT/LOAD/RUN/STEP via cpu_clr_n and cpu_ce,
// loads the program store from a byte stream, serves combinational fetch.
// Optional breakpoint support: define TD4_BREAKPOINT_EN.
module td4_prog_ctrl
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = TD4_ADDR_W,
    parameter int unsigned DATA_W = TD4_DATA_W
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [ADDR_W-1:0] ADDR_ROM,
    output logic [DATA_W-1:0] DATA_ROM,
    output logic              cpu_clr_n,
    output logic              cpu_ce,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    output logic [1:0]        state_o,
`ifdef TD4_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              bp_hit,
`endif
    td4_prog_ctrl_if.slave    ld
);
    td4_state_e        state, state_d;
    logic [ADDR_W-1:0] ptr;
    logic              clr_q, ce_q, ld_ready_q, load_done_q;
    logic              accept, last_byte, bp_stop;
    logic [DATA_W-1:0] rd_data;

    assign accept    = (state == ST_LOAD) && ld.ld_valid;
    assign last_byte = accept && (ptr == '1);

`ifdef TD4_BREAKPOINT_EN
    logic first_run, bp_hit_q;
    // The first RUN cycle ignores a match so run_req resumes past a breakpoint.
    assign bp_stop = (state == ST_RUN) && !first_run && bp_en && (ADDR_ROM == bp_addr);
    assign bp_hit  = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    // Next-state selection; HALT priority is load > halt > run > step.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_HALT: begin
                if (ld.load_start)  state_d = ST_LOAD;
                else if (halt_req)  state_d = ST_HALT;
                else if (run_req)   state_d = ST_RUN;
                else if (step_req)  state_d = ST_STEP;
            end
            ST_LOAD: if (last_byte) state_d = ST_HALT;
            ST_RUN:  if (halt_req || bp_stop) state_d = ST_HALT;
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State, load pointer and registered output decodes.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state       <= ST_HALT;
            ptr         <= '0;
            clr_q       <= 1'b0;
            ce_q        <= 1'b0;
            ld_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
`ifdef TD4_BREAKPOINT_EN
            first_run   <= 1'b0;
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            // Low while in LOAD and for the one cycle after leaving it.
            clr_q       <= (state != ST_LOAD) && (state_d != ST_LOAD);
            ce_q        <= (state_d == ST_RUN) || (state_d == ST_STEP);
            ld_ready_q  <= (state_d == ST_LOAD);
            load_done_q <= last_byte;
            if ((state == ST_HALT) && ld.load_start) begin
                ptr <= '0;
            end else if (accept) begin
                ptr <= ptr + 1'b1;
            end
`ifdef TD4_BREAKPOINT_EN
            first_run   <= (state != ST_RUN) && (state_d == ST_RUN);
            bp_hit_q    <= bp_stop;
`endif
        end
    end

    td4_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (CLK),
        .clr_n   (CLR_N),
        .we      (accept),
        .wr_addr (ptr),
        .wr_data (ld.ld_data),
        .rd_addr (ADDR_ROM),
        .rd_data (rd_data)
    );

    assign DATA_ROM     = (state == ST_LOAD) ? '0 : rd_data;
    assign cpu_clr_n    = clr_q;
    assign cpu_ce       = ce_q && !bp_stop;
    assign state_o      = state;
    assign ld.ld_ready  = ld_ready_q;
    assign ld.load_done = load_done_q;
endmodule

// File: doc/td4_prog_ctrl.md
Name: td4_prog_ctrl

Overview:
Program-memory owner and run controller for the TD4 CPU core. Holds the 16x8 program store as flops and serves the core's combinational fetch (ADDR_ROM -> DATA_ROM). Shares that store between the CPU fetch port and a byte-stream loader. Sequences the core through load/halt/run/single-step via a core reset (cpu_clr_n) and a clock enable (cpu_ce).

Parameters:
ADDR_W, 4, program address width; depth = 2**ADDR_W.
DATA_W, 8, instruction width: opcode [7:4], immediate [3:0].

Ports:
CLK  in  1  system clock
CLR_N  in  1  asynchronous active-low reset
ADDR_ROM  in  ADDR_W  fetch address (core PC)
DATA_ROM  out  DATA_W  fetched instruction
cpu_clr_n  out  1  active-low reset to core registers
cpu_ce  out  1  core clock enable; registers update only when 1
load_start  in  1  pulse: begin program load
ld_valid  in  1  loader byte valid
ld_data  in  DATA_W  loader byte
ld_ready  out  1  loader byte accepted when ld_valid & ld_ready
load_done  out  1  one-cycle pulse after final byte written
run_req  in  1  pulse: free-run
halt_req  in  1  pulse: stop
step_req  in  1  pulse: execute one instruction
state_o  out  2  current state encoding

Behaviour:
- Clock is CLK; reset is asynchronous, active-low on CLR_N. All state is flops reset by CLR_N.
- Reset values: state HALT; memory all 8'h00; write pointer 0; cpu_clr_n 0; cpu_ce 0; ld_ready 0; load_done 0.
- cpu_clr_n is registered:
  - 0 during reset and throughout LOAD.
  - 0 for exactly one cycle after LOAD exits.
  - 1 otherwise, including the first cycle after reset release.
- States and encoding: HALT=0, LOAD=1, RUN=2, STEP=3.
- HALT:
  - load_start -> LOAD, pointer cleared.
  - Otherwise run_req -> RUN.
  - Otherwise step_req -> STEP.
  - Priority: load_start > halt_req > run_req > step_req. A halt_req in HALT is a no-op but still masks run_req/step_req that cycle.
- LOAD:
  - ld_ready = 1 (registered state decode).
  - Each accepted byte: mem[ptr] <= ld_data; ptr++.
  - After the byte written at ptr = depth-1, ptr wraps to 0, next state HALT, load_done pulses 1 cycle.
  - run/halt/step/load_start are ignored in LOAD.
  - Reset mid-load: memory cleared; partial program is lost.
- RUN:
  - cpu_ce = 1 every cycle.
  - halt_req -> HALT; cpu_ce is 0 from the next cycle on.
  - run_req/step_req/load_start are ignored.
- STEP:
  - cpu_ce = 1 for exactly one cycle, then -> HALT. Exactly one core update per step_req.
- cpu_ce is a state decode: 1 in RUN and STEP only, 0 in HALT/LOAD.
- Fetch path:
  - DATA_ROM = mem[ADDR_ROM] combinationally, zero latency, in all states except LOAD.
  - In LOAD, DATA_ROM = 8'h00.
  - A write and a read of the same address in the same cycle return the old value.
- Request pulses are level-sampled every cycle. Held levels behave as repeated pulses, e.g. held step_req alternates STEP/HALT.

Optional Feature:
Macro TD4_BREAKPOINT_EN.
- With the macro, add inputs bp_en (1) and bp_addr (ADDR_W).
- In RUN, when bp_en and ADDR_ROM == bp_addr:
  - cpu_ce = 0 that cycle (combinational), so the instruction at bp_addr is not executed.
  - Next state is HALT.
  - bp_hit, a registered 1-cycle output pulse, asserts.
- The first RUN cycle after leaving HALT ignores the match, so run_req resumes past the breakpoint.
- STEP ignores breakpoints.
- Without the macro: no extra ports, RUN is never interrupted except by halt_req.

Decomposition:
- Package td4_pkg: state enum (HALT/LOAD/RUN/STEP), TD4_ADDR_W=4, TD4_DATA_W=8, opcode-field slice constants.
- Sub-module td4_prog_mem: depth x DATA_W flop array with async clear, one synchronous write port, one combinational read port.
- The FSM, pointer and output decode stay in td4_prog_ctrl.

Test Plan:
- Reset release -> state_o=0, cpu_clr_n=1, cpu_ce=0, DATA_ROM=8'h00 for every ADDR_ROM 0..15.
- load_start, then 16 bytes 8'hB0+i with ld_valid gaps of 0-2 cycles:
  - load_done pulses once after byte 16; state_o=0.
  - cpu_clr_n low during load plus 1 cycle.
  - ADDR_ROM=4'h5 -> DATA_ROM=8'hB5.
- run_req, wait 10 cycles, halt_req:
  - exactly 10 cycles of cpu_ce=1 before halt_req is sampled.
  - cpu_ce=0 from the cycle after halt_req.
- Three step_req pulses spaced 3 cycles apart in HALT -> exactly 3 single-cycle cpu_ce pulses.
- run_req and halt_req in the same cycle in HALT -> stays HALT.
- CLR_N asserted after byte 7 of a load -> immediate return to HALT; memory reads 8'h00; a new load succeeds.
- With TD4_BREAKPOINT_EN, bp_addr=4'h3, ADDR_ROM driven 0,1,2,3:
  - cpu_ce=0 at ADDR_ROM=3, bp_hit pulses, state HALT.
  - run_req then proceeds past 3.
